// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types for the seven-segment display arbiter
package ssd_pkg;

    localparam logic [31:0] SSD_BLANK = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] bits;
        logic        char_mode;
    } ssd_frame_t;

    typedef enum logic {
        IDLE,
        SHOW
    } ssd_state_t;

endpackage

// File: rtl/ssd_rr_pick.sv
// rtl/ssd_rr_pick.sv - combinational round-robin picker over a pending vector
module ssd_rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] pend,
    input  logic [W-1:0] start,
    input  logic [W-1:0] excl,
    input  logic         excl_en,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = '0;
        // Explicit wrap keeps non-power-of-2 N correct.
        for (int k = 0; k < N; k++) begin
            c = int'(start) + k;
            if (c >= N) c = c - N;
            if (!found && pend[c] && !(excl_en && c == int'(excl))) begin
                found = 1'b1;
                idx   = W'(c);
            end
        end
    end

endmodule

// File: rtl/ssd_arbiter.sv
// rtl/ssd_arbiter.sv - round-robin display arbiter with hold time; SSD_ARB_PRIORITY_EN makes requester 0 preempt
module ssd_arbiter
    import ssd_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int OWNER_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_bits,
    input  logic [NUM_REQ-1:0]    req_char_mode,
    output logic [31:0]           ssd_bits,
    output logic                  ssd_char_mode,
    output logic [OWNER_W-1:0]    owner,
    output logic                  owner_valid
);

    localparam int                HOLD_W   = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    ssd_state_t          state, state_n;
    logic [NUM_REQ-1:0]  pend;
    ssd_frame_t          frame_buf [NUM_REQ];
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                load;
    logic [OWNER_W-1:0]  load_idx;
    logic [OWNER_W-1:0]  rr_start, pick_start, pick_idx;
    logic                pick_found, expired;

    assign req_ready  = ~pend;
    assign expired    = (hold_cnt == HOLD_MAX);
    assign rr_start   = (owner == OWNER_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign pick_start = (state == IDLE) ? '0 : rr_start;

    ssd_rr_pick #(.N(NUM_REQ), .W(OWNER_W)) u_pick (
        .pend    (pend),
        .start   (pick_start),
        .excl    (owner),
        .excl_en (state == SHOW),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        load     = 1'b0;
        load_idx = owner;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load     = 1'b1;
                    load_idx = pick_idx;
                    hold_n   = '0;
                    state_n  = SHOW;
                end
            end
            default: begin
                hold_n = expired ? hold_cnt : hold_cnt + 1'b1;
`ifdef SSD_ARB_PRIORITY_EN
                if (pend[0] && owner != '0) begin
                    load     = 1'b1;
                    load_idx = '0;
                    hold_n   = '0;
                end else
`endif
                // A due switch beats the owner's refresh, which stays pending.
                if (expired && pick_found) begin
                    load     = 1'b1;
                    load_idx = pick_idx;
                    hold_n   = '0;
                end else if (pend[owner]) begin
                    load     = 1'b1;
                    load_idx = owner;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !pend[i]) begin
                frame_buf[i] <= '{bits: req_bits[32*i +: 32], char_mode: req_char_mode[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend          <= '0;
            hold_cnt      <= '0;
            owner         <= '0;
            owner_valid   <= 1'b0;
            ssd_bits      <= SSD_BLANK;
            ssd_char_mode <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                end else if (load && load_idx == OWNER_W'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            if (load) begin
                ssd_bits      <= frame_buf[load_idx].bits;
                ssd_char_mode <= frame_buf[load_idx].char_mode;
                owner         <= load_idx;
                owner_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_arbiter.sv
// tb/tb_ssd_arbiter.sv - directed self-checking bench for ssd_arbiter (NUM_REQ=2, HOLD_CYCLES=8)
module tb_ssd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_bits;
    logic [1:0]  req_char_mode;
    logic [31:0] ssd_bits;
    logic        ssd_char_mode;
    logic        owner;
    logic        owner_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    ssd_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_bits      (req_bits),
        .req_char_mode (req_char_mode),
        .ssd_bits      (ssd_bits),
        .ssd_char_mode (ssd_char_mode),
        .owner         (owner),
        .owner_valid   (owner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake happens on the edge inside this task.
    task automatic offer(input int idx, input logic [31:0] bits, input logic cm);
        req_valid[idx]          = 1'b1;
        req_bits[32*idx +: 32]  = bits;
        req_char_mode[idx]      = cm;
        step(1);
        req_valid[idx]          = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        tests_run++;
        if (ssd_bits !== 32'hFFFF_FFFF || ssd_char_mode !== 1'b0 || owner_valid !== 1'b0 || req_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset: bits=%h cm=%b ov=%b ready=%b, want ffffffff 0 0 11", ssd_bits, ssd_char_mode, owner_valid, req_ready);
        end
    endtask

    task automatic test_first_grant;
        offer(1, 32'h0A0B_0C0D, 1'b1);
        tests_run++;
        if (req_ready !== 2'b01 || ssd_bits !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL grant_pending: ready=%b bits=%h, want 01 ffffffff", req_ready, ssd_bits);
        end
        step(1);
        tests_run++;
        if (ssd_bits !== 32'h0A0B_0C0D || ssd_char_mode !== 1'b1 || owner !== 1'b1 || owner_valid !== 1'b1 || req_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL grant_load: bits=%h cm=%b owner=%b ov=%b ready=%b, want 0a0b0c0d 1 1 1 11", ssd_bits, ssd_char_mode, owner, owner_valid, req_ready);
        end
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        step(1);
        offer(0, 32'h0000_0001, 1'b0);
        for (int k = 3; k <= 7; k++) begin
            step(1);
            if (ssd_bits !== 32'h0A0B_0C0D || owner !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_keep: %0d early-change cycles, want 0", bad);
        end
        step(1);
        tests_run++;
        if (owner !== 1'b0 || ssd_bits !== 32'h0000_0001 || ssd_char_mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_switch: owner=%b bits=%h cm=%b, want 0 00000001 0", owner, ssd_bits, ssd_char_mode);
        end
    endtask

    task automatic test_refresh;
        step(1);
        offer(0, 32'h0000_0002, 1'b0);
        tests_run++;
        if (ssd_bits !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL refresh_early: bits=%h, want 00000001", ssd_bits);
        end
        step(1);
        tests_run++;
        if (ssd_bits !== 32'h0000_0002 || owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL refresh_load: bits=%h owner=%b, want 00000002 0", ssd_bits, owner);
        end
        offer(1, 32'h0000_00B1, 1'b0);
        step(2);
        tests_run++;
        if (ssd_bits !== 32'h0000_0002 || owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL refresh_hold: bits=%h owner=%b, want 00000002 0", ssd_bits, owner);
        end
    endtask

    task automatic test_simultaneous;
        offer(0, 32'h0000_0003, 1'b0);
        tests_run++;
        if (ssd_bits !== 32'h0000_0002 || owner !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_pre: bits=%h owner=%b, want 00000002 0", ssd_bits, owner);
        end
        step(1);
        tests_run++;
        if (owner !== 1'b1 || ssd_bits !== 32'h0000_00B1 || req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL simul_switch: owner=%b bits=%h ready=%b, want 1 000000b1 10", owner, ssd_bits, req_ready);
        end
`ifdef SSD_ARB_PRIORITY_EN
        step(1);
`else
        step(7);
        tests_run++;
        if (owner !== 1'b1 || req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL simul_wait: owner=%b ready=%b, want 1 10", owner, req_ready);
        end
        step(1);
`endif
        tests_run++;
        if (owner !== 1'b0 || ssd_bits !== 32'h0000_0003 || req_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL simul_regrant: owner=%b bits=%h ready=%b, want 0 00000003 11", owner, ssd_bits, req_ready);
        end
    endtask

    task automatic test_preempt;
        offer(1, 32'h0000_00C1, 1'b0);
        step(7);
        tests_run++;
        if (owner !== 1'b1 || ssd_bits !== 32'h0000_00C1) begin
            tests_failed++;
            $display("FAIL preempt_setup: owner=%b bits=%h, want 1 000000c1", owner, ssd_bits);
        end
        step(1);
        offer(0, 32'h1111_1111, 1'b0);
        step(1);
`ifdef SSD_ARB_PRIORITY_EN
        tests_run++;
        if (owner !== 1'b0 || ssd_bits !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL preempt_now: owner=%b bits=%h, want 0 11111111", owner, ssd_bits);
        end
`else
        tests_run++;
        if (owner !== 1'b1 || ssd_bits !== 32'h0000_00C1) begin
            tests_failed++;
            $display("FAIL preempt_none: owner=%b bits=%h, want 1 000000c1", owner, ssd_bits);
        end
        step(5);
        tests_run++;
        if (owner !== 1'b0 || ssd_bits !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL preempt_expiry: owner=%b bits=%h, want 0 11111111", owner, ssd_bits);
        end
`endif
    endtask

    task automatic test_expired_idle;
        step(12);
        offer(1, 32'h0000_00D1, 1'b1);
        tests_run++;
        if (owner !== 1'b0 || req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL idle_keep: owner=%b ready=%b, want 0 01", owner, req_ready);
        end
        step(1);
        tests_run++;
        if (owner !== 1'b1 || ssd_bits !== 32'h0000_00D1 || ssd_char_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_switch: owner=%b bits=%h cm=%b, want 1 000000d1 1", owner, ssd_bits, ssd_char_mode);
        end
    endtask

    task automatic test_reset_mid;
        offer(0, 32'h0000_00E1, 1'b0);
        rst_n = 1'b0;
        step(1);
        tests_run++;
        if (ssd_bits !== 32'hFFFF_FFFF || owner_valid !== 1'b0 || owner !== 1'b0 || req_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid: bits=%h ov=%b owner=%b ready=%b, want ffffffff 0 0 11", ssd_bits, owner_valid, owner, req_ready);
        end
        rst_n = 1'b1;
        step(3);
        tests_run++;
        if (ssd_bits !== 32'hFFFF_FFFF || owner_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_discard: bits=%h ov=%b, want ffffffff 0", ssd_bits, owner_valid);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 2'b00;
        req_bits      = '0;
        req_char_mode = 2'b00;
        test_reset;
        test_first_grant;
        test_hold;
        test_refresh;
        test_simultaneous;
        test_preempt;
        test_expired_idle;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
